rx_vc_buffer: RTL and testbench

- Per-virtual-channel receive buffer that sits directly downstream of the NI packet processor's NoC-receive path.
- It accepts flits from the processor as flit payload without type bits, plus a VC id, with a valid/ready handshake, and stores them in one FIFO per VC.
- The AXI slave read channel pops them per VC.
- It exports per-VC occupancy and status used for AXI read-side gating and interrupts.

---
 rtl/rx_vc_buffer_if.sv | 37 +++
 rtl/rx_vc_buffer.sv | 140 ++++++++++++++
 tb/tb_rx_vc_buffer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/rx_vc_buffer_if.sv
// Port bundle between the NoC-receive packet processor / AXI read channel
// and the per-VC receive buffer.
interface rx_vc_buffer_if #(
    parameter int NumVC         = 3,
    parameter int FlitDataWidth = 32,
    parameter int BufferDepth   = 4
);
    localparam int VcWidth  = (NumVC > 1) ? $clog2(NumVC) : 1;
    localparam int PtrWidth = $clog2(BufferDepth);
    localparam int CntWidth = PtrWidth + 1;

    logic                         pkt_in_valid_i;
    logic [FlitDataWidth-1:0]     pkt_in_data_i;
    logic [VcWidth-1:0]           pkt_in_vc_i;
    logic                         pkt_in_ready_o;
    logic                         rd_req_i;
    logic [VcWidth-1:0]           rd_vc_i;
    logic                         rd_valid_o;
    logic [FlitDataWidth-1:0]     rd_data_o;
    logic                         rd_err_o;
    logic [NumVC*CntWidth-1:0]    vc_cnt_o;
    logic [NumVC-1:0]             vc_empty_o;
    logic [NumVC-1:0]             vc_full_o;
    logic                         drop_o;

    modport master (
        output pkt_in_valid_i, pkt_in_data_i, pkt_in_vc_i, rd_req_i, rd_vc_i,
        input  pkt_in_ready_o, rd_valid_o, rd_data_o, rd_err_o,
               vc_cnt_o, vc_empty_o, vc_full_o, drop_o
    );

    modport slave (
        input  pkt_in_valid_i, pkt_in_data_i, pkt_in_vc_i, rd_req_i, rd_vc_i,
        output pkt_in_ready_o, rd_valid_o, rd_data_o, rd_err_o,
               vc_cnt_o, vc_empty_o, vc_full_o, drop_o
    );
endinterface

// File: rtl/rx_vc_buffer.sv
// Per-virtual-channel receive FIFOs between the NoC-receive path and the
// AXI read channel; zero-latency write accept, one-cycle registered pop.
module rx_vc_buffer #(
    parameter int NumVC         = 3,
    parameter int FlitDataWidth = 32,
    parameter int BufferDepth   = 4
) (
    input  logic           clk_axi,
    input  logic           arst_axi,
    rx_vc_buffer_if.slave  bus
);
    localparam int VcWidth  = (NumVC > 1) ? $clog2(NumVC) : 1;
    localparam int PtrWidth = $clog2(BufferDepth);
    localparam int CntWidth = PtrWidth + 1;
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(BufferDepth);

    logic [PtrWidth-1:0]      wr_ptr_r [NumVC];
    logic [PtrWidth-1:0]      rd_ptr_r [NumVC];
    logic [CntWidth-1:0]      cnt_r    [NumVC];
    logic [FlitDataWidth-1:0] mem_r    [NumVC][BufferDepth];

    logic [NumVC-1:0]          wr_en_s;
    logic [NumVC-1:0]          rd_en_s;
    logic [NumVC-1:0]          empty_s;
    logic [NumVC-1:0]          full_s;
    logic [NumVC*CntWidth-1:0] cnt_flat_s;
    logic                      wr_vc_ok_s;
    logic                      ready_s;
    logic                      rd_ok_s;
    logic [FlitDataWidth-1:0]  rd_data_s;

    logic                      rd_valid_r;
    logic                      rd_err_r;
    logic                      drop_r;
    logic [FlitDataWidth-1:0]  rd_data_r;

    // Occupancy flags derived purely from registered counts
    always_comb begin
        empty_s    = {NumVC{1'b0}};
        full_s     = {NumVC{1'b0}};
        cnt_flat_s = {(NumVC*CntWidth){1'b0}};
        for (int v = 0; v < NumVC; v++) begin
            empty_s[v] = (cnt_r[v] == {CntWidth{1'b0}});
            full_s[v]  = (cnt_r[v] == DepthCnt);
            cnt_flat_s[v*CntWidth +: CntWidth] = cnt_r[v];
        end
    end

    // Write decode: an out-of-range VC is always accepted and silently dropped
    always_comb begin
        wr_en_s    = {NumVC{1'b0}};
        wr_vc_ok_s = 1'b0;
        ready_s    = 1'b1;
        for (int v = 0; v < NumVC; v++) begin
            if (bus.pkt_in_vc_i == VcWidth'(v)) begin
                wr_vc_ok_s = 1'b1;
                ready_s    = ~full_s[v];
                wr_en_s[v] = bus.pkt_in_valid_i & ~full_s[v];
            end else begin
                wr_en_s[v] = 1'b0;
            end
        end
    end

    // Pop decode: no bypass, so a write landing this cycle is not visible yet
    always_comb begin
        rd_en_s   = {NumVC{1'b0}};
        rd_data_s = {FlitDataWidth{1'b0}};
        for (int v = 0; v < NumVC; v++) begin
            if (bus.rd_req_i && (bus.rd_vc_i == VcWidth'(v)) && !empty_s[v]) begin
                rd_en_s[v] = 1'b1;
                rd_data_s  = mem_r[v][rd_ptr_r[v]];
            end else begin
                rd_en_s[v] = 1'b0;
            end
        end
        rd_ok_s = |rd_en_s;
    end

    // Flit storage; contents are don't-care after reset so no reset branch
    always_ff @(posedge clk_axi) begin
        for (int v = 0; v < NumVC; v++) begin
            if (wr_en_s[v]) begin
                mem_r[v][wr_ptr_r[v]] <= bus.pkt_in_data_i;
            end
        end
    end

    // Pointers and counts; power-of-2 depth makes the increment wrap naturally
    always_ff @(posedge clk_axi) begin
        if (arst_axi) begin
            for (int v = 0; v < NumVC; v++) begin
                wr_ptr_r[v] <= {PtrWidth{1'b0}};
                rd_ptr_r[v] <= {PtrWidth{1'b0}};
                cnt_r[v]    <= {CntWidth{1'b0}};
            end
        end else begin
            for (int v = 0; v < NumVC; v++) begin
                if (wr_en_s[v]) begin
                    wr_ptr_r[v] <= wr_ptr_r[v] + PtrWidth'(1);
                end
                if (rd_en_s[v]) begin
                    rd_ptr_r[v] <= rd_ptr_r[v] + PtrWidth'(1);
                end
                case ({wr_en_s[v], rd_en_s[v]})
                    2'b10:   cnt_r[v] <= cnt_r[v] + CntWidth'(1);
                    2'b01:   cnt_r[v] <= cnt_r[v] - CntWidth'(1);
                    default: cnt_r[v] <= cnt_r[v];
                endcase
            end
        end
    end

    // Read response and drop pulse; data/err hold between responses
    always_ff @(posedge clk_axi) begin
        if (arst_axi) begin
            rd_valid_r <= 1'b0;
            rd_err_r   <= 1'b0;
            rd_data_r  <= {FlitDataWidth{1'b0}};
            drop_r     <= 1'b0;
        end else begin
            rd_valid_r <= bus.rd_req_i;
            drop_r     <= bus.pkt_in_valid_i & ~wr_vc_ok_s;
            if (bus.rd_req_i) begin
                rd_data_r <= rd_data_s;
                rd_err_r  <= ~rd_ok_s;
            end
        end
    end

    assign bus.pkt_in_ready_o = ready_s;
    assign bus.rd_valid_o     = rd_valid_r;
    assign bus.rd_data_o      = rd_data_r;
    assign bus.rd_err_o       = rd_err_r;
    assign bus.drop_o         = drop_r;
    assign bus.vc_cnt_o       = cnt_flat_s;
    assign bus.vc_empty_o     = empty_s;
    assign bus.vc_full_o      = full_s;

endmodule

// File: tb/tb_rx_vc_buffer.sv
// Directed bench for rx_vc_buffer: inputs change 1 ns after the rising edge,
// registered outputs are sampled 1 ns after the edge that produced them.
module tb_rx_vc_buffer;
    logic clk_axi  = 1'b0;
    logic arst_axi = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    rx_vc_buffer_if #(.NumVC(3), .FlitDataWidth(32), .BufferDepth(4)) bus ();

    rx_vc_buffer #(.NumVC(3), .FlitDataWidth(32), .BufferDepth(4)) dut (
        .clk_axi  (clk_axi),
        .arst_axi (arst_axi),
        .bus      (bus)
    );

    always #5 clk_axi = ~clk_axi;

    task automatic tick();
        @(posedge clk_axi);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] cnt(input int vc);
        return bus.vc_cnt_o[vc*3 +: 3];
    endfunction

    initial begin
        bus.pkt_in_valid_i = 1'b0;
        bus.pkt_in_data_i  = 32'h0;
        bus.pkt_in_vc_i    = 2'd0;
        bus.rd_req_i       = 1'b0;
        bus.rd_vc_i        = 2'd0;

        // Reset state
        tick(); tick();
        arst_axi = 1'b0;
        tick();
        chk("rst_empty", 64'(bus.vc_empty_o), 64'h7);
        chk("rst_full",  64'(bus.vc_full_o),  64'h0);
        chk("rst_cnt",   64'(bus.vc_cnt_o),   64'h0);
        chk("rst_ready", 64'(bus.pkt_in_ready_o), 64'h1);
        chk("rst_rdv",   64'(bus.rd_valid_o), 64'h0);
        chk("rst_rdd",   64'(bus.rd_data_o),  64'h0);
        chk("rst_err",   64'(bus.rd_err_o),   64'h0);
        chk("rst_drop",  64'(bus.drop_o),     64'h0);

        // Fill VC1 with A0..A3
        for (int i = 0; i < 4; i++) begin
            bus.pkt_in_valid_i = 1'b1;
            bus.pkt_in_vc_i    = 2'd1;
            bus.pkt_in_data_i  = 32'hA0 + 32'(i);
            #1;
            chk("fill_ready", 64'(bus.pkt_in_ready_o), 64'h1);
            tick();
        end
        bus.pkt_in_valid_i = 1'b0;
        #1;
        chk("vc1_full",   64'(bus.vc_full_o), 64'h2);
        chk("vc1_cnt4",   64'(cnt(1)), 64'h4);
        chk("vc1_empty",  64'(bus.vc_empty_o), 64'h5);
        chk("full_ready", 64'(bus.pkt_in_ready_o), 64'h0);

        // Write to full VC1 with simultaneous pop: write refused, pop gets A0
        bus.pkt_in_valid_i = 1'b1;
        bus.pkt_in_data_i  = 32'hFF;
        bus.rd_req_i       = 1'b1;
        bus.rd_vc_i        = 2'd1;
        #1;
        chk("full_pop_ready", 64'(bus.pkt_in_ready_o), 64'h0);
        tick();
        chk("full_pop_v",   64'(bus.rd_valid_o), 64'h1);
        chk("full_pop_d",   64'(bus.rd_data_o),  64'hA0);
        chk("full_pop_e",   64'(bus.rd_err_o),   64'h0);
        chk("full_pop_cnt", 64'(cnt(1)), 64'h3);

        // Next write (A4) accepted while popping A1; count stays 3
        bus.pkt_in_data_i = 32'hA4;
        #1;
        chk("rewrite_ready", 64'(bus.pkt_in_ready_o), 64'h1);
        tick();
        chk("wp_d",   64'(bus.rd_data_o), 64'hA1);
        chk("wp_cnt", 64'(cnt(1)), 64'h3);
        bus.pkt_in_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b2b_v", 64'(bus.rd_valid_o), 64'h1);
            chk("b2b_d", 64'(bus.rd_data_o),  64'hA2 + 64'(i));
            chk("b2b_e", 64'(bus.rd_err_o),   64'h0);
        end
        bus.rd_req_i = 1'b0;
        tick();
        chk("idle_v",    64'(bus.rd_valid_o), 64'h0);
        chk("hold_d",    64'(bus.rd_data_o),  64'hA4);
        chk("vc1_drain", 64'(cnt(1)), 64'h0);
        chk("all_empty", 64'(bus.vc_empty_o), 64'h7);

        // Pop empty VC2 while writing 0x55 to it: error, flit retained
        bus.pkt_in_valid_i = 1'b1;
        bus.pkt_in_vc_i    = 2'd2;
        bus.pkt_in_data_i  = 32'h55;
        bus.rd_req_i       = 1'b1;
        bus.rd_vc_i        = 2'd2;
        tick();
        chk("nobyp_v",   64'(bus.rd_valid_o), 64'h1);
        chk("nobyp_e",   64'(bus.rd_err_o),   64'h1);
        chk("nobyp_d",   64'(bus.rd_data_o),  64'h0);
        chk("nobyp_cnt", 64'(cnt(2)), 64'h1);
        bus.pkt_in_valid_i = 1'b0;
        tick();
        chk("vc2_d", 64'(bus.rd_data_o), 64'h55);
        chk("vc2_e", 64'(bus.rd_err_o),  64'h0);
        bus.rd_req_i = 1'b0;
        tick();
        chk("vc2_idle_v", 64'(bus.rd_valid_o), 64'h0);
        chk("vc2_hold_e", 64'(bus.rd_err_o),   64'h0);

        // VC0: 6 writes (C0..C5) interleaved with 6 pops, both pointers wrap
        bus.pkt_in_vc_i = 2'd0;
        bus.rd_vc_i     = 2'd0;
        for (int k = 0; k < 9; k++) begin
            bus.pkt_in_valid_i = (k < 6);
            bus.pkt_in_data_i  = 32'hC0 + 32'(k);
            bus.rd_req_i       = (k >= 3);
            tick();
            if (k >= 3) begin
                chk("wrap_d", 64'(bus.rd_data_o), 64'hC0 + 64'(k - 3));
                chk("wrap_e", 64'(bus.rd_err_o),  64'h0);
            end
            if (k == 2 || k == 5) begin
                chk("wrap_cnt3", 64'(cnt(0)), 64'h3);
            end
        end
        bus.pkt_in_valid_i = 1'b0;
        bus.rd_req_i       = 1'b0;
        tick();
        chk("wrap_cnt0", 64'(cnt(0)), 64'h0);

        // Invalid VC write is accepted and dropped; invalid VC read errors
        bus.pkt_in_valid_i = 1'b1;
        bus.pkt_in_vc_i    = 2'd3;
        bus.pkt_in_data_i  = 32'hDEAD;
        bus.rd_req_i       = 1'b1;
        bus.rd_vc_i        = 2'd3;
        #1;
        chk("inv_ready", 64'(bus.pkt_in_ready_o), 64'h1);
        tick();
        chk("inv_drop", 64'(bus.drop_o),     64'h1);
        chk("inv_cnt",  64'(bus.vc_cnt_o),   64'h0);
        chk("inv_rd_e", 64'(bus.rd_err_o),   64'h1);
        chk("inv_rd_d", 64'(bus.rd_data_o),  64'h0);
        bus.pkt_in_valid_i = 1'b0;
        bus.rd_req_i       = 1'b0;
        tick();
        chk("drop_pulse", 64'(bus.drop_o), 64'h0);

        // Reset with 2 entries in VC0 and a pop pending
        bus.pkt_in_valid_i = 1'b1;
        bus.pkt_in_vc_i    = 2'd0;
        bus.pkt_in_data_i  = 32'h11;
        tick();
        bus.pkt_in_data_i  = 32'h22;
        tick();
        bus.pkt_in_valid_i = 1'b0;
        chk("pre_rst_cnt", 64'(cnt(0)), 64'h2);
        bus.rd_req_i = 1'b1;
        bus.rd_vc_i  = 2'd0;
        arst_axi     = 1'b1;
        tick();
        chk("mid_rst_v",     64'(bus.rd_valid_o), 64'h0);
        chk("mid_rst_empty", 64'(bus.vc_empty_o), 64'h7);
        chk("mid_rst_cnt",   64'(bus.vc_cnt_o),   64'h0);
        bus.rd_req_i = 1'b0;
        arst_axi     = 1'b0;
        bus.rd_req_i = 1'b1;
        tick();
        chk("post_rst_e", 64'(bus.rd_err_o), 64'h1);
        bus.rd_req_i = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
